// File: rtl/sevenseg_pkg.sv
// -----------------------------------------------------------------------------
// sevenseg_pkg
// Shared definitions for the seven-segment display path. The encoder
// (sevenseg_mux) and the decoder (sevenseg_scan_decoder) both import this
// package, so they use a single segment table.
//
// Segment bit order is {g,f,e,d,c,b,a}: bit 6 = g ... bit 0 = a.
// All patterns are active-low: a 0 bit lights that segment.
// -----------------------------------------------------------------------------
package sevenseg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Per-slot capture FSM.
    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2
    } scan_state_t;

    // Result of checking an anode vector for exactly one low bit.
    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } slot_sel_t;

    function automatic slot_sel_t decode_anode(input logic [3:0] an);
        slot_sel_t r;
        r.valid = 1'b1;
        r.idx   = 2'd0;
        case (an)
            4'b1110: r.idx = 2'd0;
            4'b1101: r.idx = 2'd1;
            4'b1011: r.idx = 2'd2;
            4'b0111: r.idx = 2'd3;
            default: r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sevenseg_pattern_decode.sv
// -----------------------------------------------------------------------------
// sevenseg_pattern_decode
// Pure combinational decode of one active-low segment pattern back to hex.
//
// Ports:
//   seg    in  7  segment pattern {g,f,e,d,c,b,a}, active-low
//   digit  out 4  decoded hex value (4'hF for blank or unknown patterns)
//   blank  out 1  pattern has every segment off
//   bad    out 1  pattern is neither a hex glyph nor blank
// -----------------------------------------------------------------------------
module sevenseg_pattern_decode
    import sevenseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       blank,
    output logic       bad
);

    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        digit = 4'hF;
        blank = 1'b0;
        bad   = 1'b0;
        case (seg)
            SEG_0:     digit = 4'h0;
            SEG_1:     digit = 4'h1;
            SEG_2:     digit = 4'h2;
            SEG_3:     digit = 4'h3;
            SEG_4:     digit = 4'h4;
            SEG_5:     digit = 4'h5;
            SEG_6:     digit = 4'h6;
            SEG_7:     digit = 4'h7;
            SEG_8:     digit = 4'h8;
            SEG_9:     digit = 4'h9;
            SEG_A:     digit = 4'hA;
            SEG_B:     digit = 4'hB;
            SEG_C:     digit = 4'hC;
            SEG_D:     digit = 4'hD;
            SEG_E:     digit = 4'hE;
            SEG_F:     digit = 4'hF;
            SEG_BLANK: blank = 1'b1;
            default:   bad   = 1'b1;
        endcase
    end

endmodule

// File: rtl/sevenseg_scan_decoder.sv
// -----------------------------------------------------------------------------
// sevenseg_scan_decoder
// Receive side of the multiplexed seven-segment bus. Samples {an,seg,dp},
// waits for SETTLE identical samples, captures the slot once per anode
// dwell, and publishes all four digits together when a frame completes.
//
// Ports:
//   clk          in   1  system clock
//   rst          in   1  asynchronous, active-high reset
//   an           in   4  anode enables, active-low, one-hot-low expected
//   seg          in   7  segments {g,f,e,d,c,b,a}, active-low
//   dp           in   1  decimal point, active-low
//   d3..d0       out  4  decoded digits, refreshed on frame_valid
//   dp_out       out  4  per-digit decimal point, 1 = lit
//   blank        out  4  per-digit, 1 = all segments off (digit reads 4'hF)
//   frame_valid  out  1  one-cycle pulse when all outputs are refreshed
//   pat_err      out  1  sticky: unknown segment pattern captured this frame
//   an_err       out  1  sticky: stable anode vector was not one-hot-low
//   stale        out  1  no capture for TIMEOUT cycles
// -----------------------------------------------------------------------------
module sevenseg_scan_decoder
    import sevenseg_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1_000_000,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] an,
    input  logic [6:0] seg,
    input  logic       dp,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic [3:0] dp_out,
    output logic [3:0] blank,
    output logic       frame_valid,
    output logic       pat_err,
    output logic       an_err,
    output logic       stale
);

    localparam int                STAB_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TIMEOUT);

    // Sample layout: [11:8] an, [7:1] seg, [0] dp.
    logic [11:0]       in_q;
    logic [11:0]       cap_q;
    logic [STAB_W-1:0] stab_q;

    scan_state_t state_q, state_d;
    logic        capture;
    logic        load_cap;

    logic [3:0]       dec_digit;
    logic             dec_blank;
    logic             dec_bad;
    slot_sel_t        sel;
    logic             cap_ok;
    logic             cap_bad_an;
    logic [3:0]       mask_q, mask_d;
    logic             frame_done;

    logic [3:0][3:0]  sh_digit_q, sh_digit_d;
    logic [3:0]       sh_blank_q, sh_blank_d;
    logic [3:0]       sh_dp_q, sh_dp_d;
    logic [3:0][3:0]  d_q;
    logic [CNT_W-1:0] cnt_q;

    // ---------------- input register and stability counter ----------------
    // NOTE: state in clocked blocks uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q   <= '1;
            stab_q <= '0;
        end else begin
            in_q <= {an, seg, dp};
            // stab_q counts how many further cycles in_q has held its value.
            if ({an, seg, dp} != in_q)
                stab_q <= '0;
            else if (stab_q != STAB_LAST)
                stab_q <= stab_q + STAB_W'(1);
        end
    end

    // ---------------- capture FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_WAIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT:    if (stab_q == STAB_LAST) state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_HOLD;
            // Leave HOLD only once the bus moves off the captured sample, so
            // one dwell yields one capture.
            ST_HOLD:    if (in_q != cap_q) state_d = ST_WAIT;
            default:    state_d = ST_WAIT;
        endcase
    end

    always_comb begin
        capture  = (state_q == ST_CAPTURE);
        load_cap = (state_q == ST_WAIT) && (state_d == ST_CAPTURE);
    end

    // The settled sample is frozen in cap_q so a bus change on the same
    // edge cannot corrupt what CAPTURE writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           cap_q <= '1;
        else if (load_cap) cap_q <= in_q;
    end

    // ---------------- decode and shadow update ----------------
    sevenseg_pattern_decode u_decode (
        .seg   (cap_q[7:1]),
        .digit (dec_digit),
        .blank (dec_blank),
        .bad   (dec_bad)
    );

    always_comb begin
        sel        = decode_anode(cap_q[11:8]);
        cap_ok     = capture && sel.valid;
        cap_bad_an = capture && !sel.valid;
        mask_d     = mask_q;
        sh_digit_d = sh_digit_q;
        sh_blank_d = sh_blank_q;
        sh_dp_d    = sh_dp_q;
        if (cap_ok) begin
            mask_d[sel.idx]     = 1'b1;
            sh_digit_d[sel.idx] = dec_digit;
            sh_blank_d[sel.idx] = dec_blank;
            sh_dp_d[sel.idx]    = ~cap_q[0];
        end
        frame_done = cap_ok && (mask_d == 4'b1111);
    end

    // ---------------- shadow, outputs, flags, timeout ----------------
    // NOTE: the four-entry shadow is plain registers, not a RAM, so it is
    // reset like any other state; a reset mid-frame leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask_q      <= '0;
            sh_digit_q  <= {4{4'hF}};
            sh_blank_q  <= 4'b1111;
            sh_dp_q     <= 4'b0000;
            d_q         <= {4{4'hF}};
            blank       <= 4'b1111;
            dp_out      <= 4'b0000;
            frame_valid <= 1'b0;
            pat_err     <= 1'b0;
            an_err      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sh_digit_q  <= sh_digit_d;
            sh_blank_q  <= sh_blank_d;
            sh_dp_q     <= sh_dp_d;
            frame_valid <= frame_done;
            if (frame_done) begin
                mask_q <= '0;
                d_q    <= sh_digit_d;
                blank  <= sh_blank_d;
                dp_out <= sh_dp_d;
            end else begin
                mask_q <= mask_d;
            end

            // Flags clear after the frame_valid cycle that reported them;
            // a fresh error in that same cycle takes priority.
            if (cap_ok && dec_bad) pat_err <= 1'b1;
            else if (frame_valid)  pat_err <= 1'b0;
            if (cap_bad_an)        an_err  <= 1'b1;
            else if (frame_valid)  an_err  <= 1'b0;

            if (capture)              cnt_q <= '0;
            else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign stale = (cnt_q == CNT_MAX);
    assign d3    = d_q[3];
    assign d2    = d_q[2];
    assign d1    = d_q[1];
    assign d0    = d_q[0];

endmodule
